// File: rtl/multirate_v4_mac_accum.sv
// multirate_v4_mac_accum
//   Multiply-accumulate back end of a decimating FIR. Sums NUM_TAPS signed
//   products per output sample, rounds half-up and drops SHIFT fraction bits,
//   then saturates to OUT_WIDTH and holds the result in a one-deep output
//   register with a valid/ready handshake.
//
// Ports
//   ap_clk       in   sole clock, rising edge
//   ap_rst_n     in   asynchronous active-low reset
//   clr          in   synchronous discard of the partial accumulation
//   prod_tdata   in   [PROD_WIDTH] signed product
//   prod_tvalid  in   product valid
//   prod_tready  out  product accepted this cycle when valid
//   y_tdata      out  [OUT_WIDTH] signed filtered sample
//   y_tvalid     out  output sample valid
//   y_tready     in   downstream accepts sample
//   sat_pulse    out  one-cycle flag: the sample just loaded was clamped
module multirate_v4_mac_accum #(
    parameter int NUM_TAPS   = 16,
    parameter int PROD_WIDTH = 26,
    parameter int ACC_WIDTH  = 34,
    parameter int SHIFT      = 9,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  clr,
    input  logic [PROD_WIDTH-1:0] prod_tdata,
    input  logic                  prod_tvalid,
    output logic                  prod_tready,
    output logic [OUT_WIDTH-1:0]  y_tdata,
    output logic                  y_tvalid,
    input  logic                  y_tready,
    output logic                  sat_pulse
);

    localparam int CNT_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NUM_TAPS - 1);
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

    // Rounding offset and clamp limits, one bit wider than the accumulator so
    // the half-LSB addition can never wrap.
    localparam logic signed [ACC_WIDTH:0] RND  = (SHIFT > 0) ? ((ACC_WIDTH+1)'(1) << RND_SH) : '0;
    localparam logic signed [ACC_WIDTH:0] MAXV =
        $signed({{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
    localparam logic signed [ACC_WIDTH:0] MINV =
        $signed({{(ACC_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}});

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [CNT_W-1:0]            tap_cnt;
    logic signed [ACC_WIDTH-1:0] acc;
    logic [0:0]                  out_state;

    logic                        is_last;
    logic                        beat;
    logic                        last_beat;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic signed [ACC_WIDTH:0]   rounded;
    logic [OUT_WIDTH-1:0]        clamped;
    logic                        sat;

    assign is_last  = (tap_cnt == LAST_TAP);
    assign y_tvalid = (out_state == ST_FULL);

    // Only the final tap can stall, and only when the held sample is not
    // being drained; earlier taps keep flowing while a sample is held.
    assign prod_tready = !(is_last && y_tvalid && !y_tready);

    // clr suppresses the beat but does not touch the ready it is offered.
    assign beat      = prod_tvalid && prod_tready && !clr;
    assign last_beat = beat && is_last;

    assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){prod_tdata[PROD_WIDTH-1]}}, prod_tdata};

    always_comb begin
        acc_next = (tap_cnt == '0) ? prod_ext : acc + prod_ext;
        rounded  = ($signed({acc_next[ACC_WIDTH-1], acc_next}) + RND) >>> SHIFT;
        clamped  = rounded[OUT_WIDTH-1:0];
        sat      = 1'b0;
        if (rounded > MAXV) begin
            clamped = {1'b0, {(OUT_WIDTH-1){1'b1}}};
            sat     = 1'b1;
        end else if (rounded < MINV) begin
            clamped = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            sat     = 1'b1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            tap_cnt <= '0;
            acc     <= '0;
        end else if (clr) begin
            tap_cnt <= '0;
        end else if (beat) begin
            acc     <= acc_next;
            tap_cnt <= is_last ? '0 : tap_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_state <= ST_EMPTY;
            y_tdata   <= '0;
            sat_pulse <= 1'b0;
        end else begin
            sat_pulse <= last_beat && sat;
            if (last_beat) begin
                // Loading wins over a same-cycle drain: register stays FULL.
                out_state <= ST_FULL;
                y_tdata   <= clamped;
            end else if (out_state == ST_FULL && y_tready) begin
                out_state <= ST_EMPTY;
            end
        end
    end

endmodule

// File: doc/multirate_v4_mac_accum.md
MULTIRATE_V4_MAC_ACCUM -- requirements
Module: multirate_v4_mac_accum

Interface
REQ-001 SHALL provide parameter NUM_TAPS, default 16: number of products summed per output sample (range 2..256).
REQ-002 SHALL provide parameter PROD_WIDTH, default 26: signed product width from the upstream 16s x 10s multiplier.
REQ-003 SHALL provide parameter ACC_WIDTH, default 34: signed accumulator width; SHALL be at least PROD_WIDTH + ceil(log2(NUM_TAPS)).
REQ-004 SHALL provide parameter SHIFT, default 9: right-shift that removes coefficient fraction bits.
REQ-005 SHALL provide parameter OUT_WIDTH, default 16: signed output sample width.
REQ-006 ap_clk  in  1  sole clock; all state changes on its rising edge.
REQ-007 ap_rst_n  in  1  asynchronous, active-low reset.
REQ-008 clr  in  1  synchronous discard of the partial accumulation.
REQ-009 prod_tdata  in  PROD_WIDTH  signed product.
REQ-010 prod_tvalid  in  1  product valid.
REQ-011 prod_tready  out  1  block accepts product.
REQ-012 y_tdata  out  OUT_WIDTH  signed filtered sample.
REQ-013 y_tvalid  out  1  output sample valid.
REQ-014 y_tready  in  1  downstream accepts sample.
REQ-015 sat_pulse  out  1  one-cycle flag: the sample just loaded was saturated.

Function
REQ-016 A product SHALL be accepted only in a cycle where prod_tvalid = 1 and prod_tready = 1 (a beat).
REQ-017 tap_cnt (0..NUM_TAPS-1) SHALL advance by 1 per beat and wrap from NUM_TAPS-1 to 0.
REQ-018 On a beat with tap_cnt = 0, acc SHALL load sign-extended prod_tdata; on any other beat, acc SHALL become acc + sign-extended prod_tdata.
REQ-019 The beat with tap_cnt = NUM_TAPS-1 is the last beat; final sum S = acc + ext(prod_tdata), formed combinationally.
REQ-020 On the last beat, R = (S + 2^(SHIFT-1)) >>> SHIFT (round half up, arithmetic shift).
REQ-021 On the last beat, y_tdata SHALL register R clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; y_tvalid SHALL be set the next cycle (latency 1 from last beat).
REQ-022 sat_pulse SHALL be 1 for exactly the cycle after a last beat in which clamping changed the value; otherwise 0.
REQ-023 Output register states: EMPTY (y_tvalid = 0) and FULL (y_tvalid = 1).
REQ-024 FULL -> EMPTY when y_tready = 1 with no simultaneous last beat.
REQ-025 A last beat and an output handshake in the same cycle SHALL leave the register FULL holding the new sample.
REQ-026 prod_tready SHALL be 0 only when tap_cnt = NUM_TAPS-1, y_tvalid = 1 and y_tready = 0; otherwise 1.
REQ-027 Non-last beats SHALL therefore proceed while a sample is held.
REQ-028 y_tdata SHALL remain stable while y_tvalid = 1 and y_tready = 0.
REQ-029 clr = 1 SHALL set tap_cnt to 0, ignore any beat in that cycle, and leave acc, y_tdata and y_tvalid unchanged; prod_tready is unaffected.
REQ-030 Intermediate acc overflow cannot occur given REQ-003; no wrap handling is required.

Reset
REQ-031 ap_rst_n = 0 SHALL immediately force tap_cnt = 0, acc = 0, y_tdata = 0, y_tvalid = 0 and sat_pulse = 0; prod_tready then evaluates to 1.
REQ-032 Reset asserted mid-frame SHALL discard the partial sum; the first beat after release SHALL be treated as tap 0.

Verification (NUM_TAPS = 4, SHIFT = 9, defaults otherwise)
REQ-033 Basic: four beats of 512, y_tready = 1 -> S = 2048, y_tdata = 4 one cycle after beat 4, sat_pulse = 0.
REQ-034 Rounding: beats 0, 0, 0, 256 -> y_tdata = 1; beats 0, 0, 0, -256 -> y_tdata = 0; beats 0, 0, 0, -257 -> y_tdata = -1.
REQ-035 Saturation: four beats of 2^24 -> y_tdata = 32767 with sat_pulse = 1; four beats of -2^24 -> y_tdata = -32768 with sat_pulse = 1.
REQ-036 Backpressure: y_tready = 0 with a sample held -> beats 1-3 of the next frame accepted, prod_tready = 0 at tap 3 until y_tready = 1; first sample is read unchanged, second follows with no loss.
REQ-037 clr after two beats of 1000 -> next four beats of 512 yield 4, not 8.
REQ-038 Reset after two beats -> all outputs 0, prod_tready = 1; the next four beats of 512 yield 4.
